// File: rtl/depacketizer_pkg.sv
// Shared types and packet field offsets for the PE input-port depacketizer.
package depacketizer_pkg;

    typedef enum logic {
        PKT_IFMAP  = 1'b0,
        PKT_FILTER = 1'b1
    } pkt_type_t;

    typedef enum logic {
        IDLE   = 1'b0,
        UNPACK = 1'b1
    } dp_state_t;

    // Packet layout, MSB first: timestep, type, filter_row, data (word0 at LSBs).
    function automatic int unsigned TS_BIT(input int unsigned pktW);
        return pktW - 1;
    endfunction

    function automatic int unsigned TYPE_BIT(input int unsigned pktW);
        return pktW - 2;
    endfunction

    function automatic int unsigned ROW_LSB(input int unsigned numWords, input int unsigned dataWidth);
        return numWords * dataWidth;
    endfunction

endpackage

// File: rtl/depacketizer_stream_word_select.sv
// Combinational word[idx] mux over the latched packet data field.
module word_select #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_WORDS  = 3,
    parameter int unsigned IDX_W      = $clog2(NUM_WORDS)
) (
    input  logic [NUM_WORDS*DATA_WIDTH-1:0] data,
    input  logic [IDX_W-1:0]                idx,
    output logic [DATA_WIDTH-1:0]           selWord
);

    // Unused idx codes (non-power-of-two NUM_WORDS) select zero.
    always_comb begin
        selWord = '0;
        for (int i = 0; i < int'(NUM_WORDS); i++) begin
            if (idx == IDX_W'(i)) begin
                selWord = data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule

// File: rtl/depacketizer_stream.sv
// Depacketizer: serialises one packet into per-word beats on the ifmap or filter stream.
module depacketizer_stream
    import depacketizer_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = 8,
    parameter  int unsigned NUM_WORDS  = 3,
    parameter  int unsigned ROW_BITS   = 2,
    parameter  int unsigned NUM_ROWS   = 3,
    parameter  int unsigned CNT_W      = 8,
    localparam int unsigned PKT_W      = NUM_WORDS*DATA_WIDTH + ROW_BITS + 2,
    localparam int unsigned IDX_W      = $clog2(NUM_WORDS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PKT_W-1:0]      in_packet,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] ifmap_word,
    output logic                  ifmap_timestep,
    output logic                  ifmap_last,
    output logic                  ifmap_valid,
    input  logic                  ifmap_ready,
    output logic [DATA_WIDTH-1:0] filter_word,
    output logic [ROW_BITS-1:0]   filter_row,
    output logic [IDX_W-1:0]      filter_idx,
    output logic                  filter_last,
    output logic                  filter_valid,
    input  logic                  filter_ready,
    output logic [CNT_W-1:0]      drop_count
);

    localparam int unsigned    DATA_BITS = NUM_WORDS * DATA_WIDTH;
    localparam int unsigned    TS_B      = TS_BIT(PKT_W);
    localparam int unsigned    TYPE_B    = TYPE_BIT(PKT_W);
    localparam int unsigned    ROW_B     = ROW_LSB(NUM_WORDS, DATA_WIDTH);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_WORDS - 1);
    localparam logic [ROW_BITS:0] ROW_LIMIT = (ROW_BITS+1)'(NUM_ROWS);

    dp_state_t             state;
    pkt_type_t             typeQ;
    logic                  tsQ;
    logic [ROW_BITS-1:0]   rowQ;
    logic [DATA_BITS-1:0]  dataQ;
    logic [IDX_W-1:0]      idxQ;
    logic                  ifmapValidQ;
    logic                  filterValidQ;
    logic [CNT_W-1:0]      dropCountQ;
    logic [DATA_WIDTH-1:0] curWord;

    pkt_type_t             inType;
    logic [ROW_BITS-1:0]   inRow;
    logic                  dropPkt;
    logic                  accept;
    logic                  selReady;
    logic                  lastBeat;
    logic                  beatDone;

    assign inType   = pkt_type_t'(in_packet[TYPE_B]);
    assign inRow    = in_packet[ROW_B +: ROW_BITS];
    assign dropPkt  = (inType == PKT_FILTER) && ({1'b0, inRow} >= ROW_LIMIT);
    assign selReady = (typeQ == PKT_FILTER) ? filter_ready : ifmap_ready;
    assign lastBeat = (idxQ == LAST_IDX);
    assign beatDone = (ifmapValidQ || filterValidQ) && selReady;

    // Ready path from downstream lets a new packet enter on the last-word handshake.
    assign in_ready = (state == IDLE) || ((state == UNPACK) && lastBeat && selReady);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            typeQ        <= PKT_IFMAP;
            tsQ          <= 1'b0;
            rowQ         <= '0;
            dataQ        <= '0;
            idxQ         <= '0;
            ifmapValidQ  <= 1'b0;
            filterValidQ <= 1'b0;
            dropCountQ   <= '0;
        end else begin
            case (state)
                IDLE: ;
                UNPACK: begin
                    if (beatDone) begin
                        if (lastBeat) begin
                            state        <= IDLE;
                            idxQ         <= '0;
                            ifmapValidQ  <= 1'b0;
                            filterValidQ <= 1'b0;
                        end else begin
                            idxQ <= idxQ + IDX_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            // An accept overrides the end-of-packet return to IDLE.
            if (accept) begin
                if (dropPkt) begin
                    if (dropCountQ != '1) begin
                        dropCountQ <= dropCountQ + CNT_W'(1);
                    end
                end else begin
                    state        <= UNPACK;
                    typeQ        <= inType;
                    tsQ          <= in_packet[TS_B];
                    rowQ         <= inRow;
                    dataQ        <= in_packet[DATA_BITS-1:0];
                    idxQ         <= '0;
                    ifmapValidQ  <= (inType == PKT_IFMAP);
                    filterValidQ <= (inType == PKT_FILTER);
                end
            end
        end
    end

    word_select #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_WORDS  (NUM_WORDS),
        .IDX_W      (IDX_W)
    ) u_word_select (
        .data    (dataQ),
        .idx     (idxQ),
        .selWord (curWord)
    );

    assign ifmap_word     = curWord;
    assign ifmap_timestep = tsQ;
    assign ifmap_last     = ifmapValidQ && lastBeat;
    assign ifmap_valid    = ifmapValidQ;
    assign filter_word    = curWord;
    assign filter_row     = rowQ;
    assign filter_idx     = idxQ;
    assign filter_last    = filterValidQ && lastBeat;
    assign filter_valid   = filterValidQ;
    assign drop_count     = dropCountQ;

endmodule

// File: tb/tb_depacketizer_stream.sv
// Directed plus randomized bench for depacketizer_stream against a queue-based packet model.
module tb_depacketizer_stream;

    localparam int unsigned DW    = 8;
    localparam int unsigned NW    = 3;
    localparam int unsigned RB    = 2;
    localparam int unsigned NR    = 3;
    localparam int unsigned CW    = 8;
    localparam int unsigned PKT_W = NW*DW + RB + 2;
    localparam int unsigned IDX_W = $clog2(NW);

    typedef struct {
        logic [DW-1:0]    w;
        logic             ts;
        logic [RB-1:0]    row;
        logic [IDX_W-1:0] idx;
        logic             last;
    } beat_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [PKT_W-1:0] in_packet;
    logic             in_valid;
    logic             in_ready;
    logic [DW-1:0]    ifmap_word;
    logic             ifmap_timestep;
    logic             ifmap_last;
    logic             ifmap_valid;
    logic             ifmap_ready;
    logic [DW-1:0]    filter_word;
    logic [RB-1:0]    filter_row;
    logic [IDX_W-1:0] filter_idx;
    logic             filter_last;
    logic             filter_valid;
    logic             filter_ready;
    logic [CW-1:0]    drop_count;

    depacketizer_stream dut (
        .clk            (clk),
        .rst            (rst),
        .in_packet      (in_packet),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .ifmap_word     (ifmap_word),
        .ifmap_timestep (ifmap_timestep),
        .ifmap_last     (ifmap_last),
        .ifmap_valid    (ifmap_valid),
        .ifmap_ready    (ifmap_ready),
        .filter_word    (filter_word),
        .filter_row     (filter_row),
        .filter_idx     (filter_idx),
        .filter_last    (filter_last),
        .filter_valid   (filter_valid),
        .filter_ready   (filter_ready),
        .drop_count     (drop_count)
    );

    always #5 clk = ~clk;

    int               vectors = 0;
    int               errors  = 0;
    logic [PKT_W-1:0] sendQ[$];
    beat_t            ifQ[$];
    beat_t            fQ[$];
    int               dropExp = 0;
    logic             offering = 1'b0;
    logic             randGaps = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model: a packet is accepted whenever no beats are owed, or only the last owed beat is being taken.
    function automatic logic expReady();
        int n = ifQ.size() + fQ.size();
        if (n == 0) return 1'b1;
        if (n == 1) return (ifQ.size() == 1) ? ifmap_ready : filter_ready;
        return 1'b0;
    endfunction

    task automatic modelAccept(input logic [PKT_W-1:0] p);
        logic          ts   = p[PKT_W-1];
        logic          typ  = p[PKT_W-2];
        logic [RB-1:0] row  = p[NW*DW +: RB];
        beat_t         b;
        if (typ && (int'(row) >= int'(NR))) begin
            if (dropExp < 255) dropExp++;
            return;
        end
        for (int i = 0; i < int'(NW); i++) begin
            b.w    = p[i*DW +: DW];
            b.ts   = ts;
            b.row  = row;
            b.idx  = IDX_W'(i);
            b.last = (i == int'(NW) - 1);
            if (typ) fQ.push_back(b);
            else     ifQ.push_back(b);
        end
    endtask

    // One clock: drive, check at the falling edge, advance the model, then move past the rising edge.
    task automatic cycle();
        logic er;
        if (!offering && sendQ.size() > 0 && (!randGaps || $urandom_range(3) != 0)) offering = 1'b1;
        in_valid  = offering;
        in_packet = (sendQ.size() > 0) ? sendQ[0] : '0;
        @(negedge clk);
        er = expReady();
        chk("in_ready", 32'(in_ready), 32'(er));
        chk("ifmap_valid", 32'(ifmap_valid), 32'(ifQ.size() > 0));
        chk("filter_valid", 32'(filter_valid), 32'(fQ.size() > 0));
        chk("drop_count", 32'(drop_count), 32'(dropExp));
        if (ifQ.size() > 0) begin
            chk("ifmap_word", 32'(ifmap_word), 32'(ifQ[0].w));
            chk("ifmap_ts", 32'(ifmap_timestep), 32'(ifQ[0].ts));
            chk("ifmap_last", 32'(ifmap_last), 32'(ifQ[0].last));
            if (ifmap_ready) void'(ifQ.pop_front());
        end
        if (fQ.size() > 0) begin
            chk("filter_word", 32'(filter_word), 32'(fQ[0].w));
            chk("filter_row", 32'(filter_row), 32'(fQ[0].row));
            chk("filter_idx", 32'(filter_idx), 32'(fQ[0].idx));
            chk("filter_last", 32'(filter_last), 32'(fQ[0].last));
            if (filter_ready) void'(fQ.pop_front());
        end
        if (offering && er) begin
            modelAccept(sendQ.pop_front());
            offering = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        int left = budget;
        while (sendQ.size() > 0 || offering || ifQ.size() > 0 || fQ.size() > 0) begin
            if (left == 0) begin
                errors++;
                $error("FAIL drain_timeout: observed %0d beats outstanding expected 0", ifQ.size() + fQ.size());
                break;
            end
            left--;
            cycle();
        end
        cycle();
    endtask

    task automatic doReset();
        rst      = 1'b1;
        in_valid = 1'b0;
        offering = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        ifQ.delete();
        fQ.delete();
        dropExp = 0;
        @(negedge clk);
        chk("rst_ifmap_valid", 32'(ifmap_valid), 32'd0);
        chk("rst_filter_valid", 32'(filter_valid), 32'd0);
        chk("rst_ifmap_word", 32'(ifmap_word), 32'd0);
        chk("rst_filter_word", 32'(filter_word), 32'd0);
        chk("rst_filter_row", 32'(filter_row), 32'd0);
        chk("rst_filter_idx", 32'(filter_idx), 32'd0);
        chk("rst_ifmap_last", 32'(ifmap_last), 32'd0);
        chk("rst_filter_last", 32'(filter_last), 32'd0);
        chk("rst_drop_count", 32'(drop_count), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst          = 1'b1;
        in_valid     = 1'b0;
        in_packet    = '0;
        ifmap_ready  = 1'b1;
        filter_ready = 1'b1;
        @(posedge clk);
        #1;
        doReset();

        // Single ifmap packet, timestep 1.
        sendQ.push_back(28'h80C0B0A);
        drain(20);

        // Single filter packet, row 2.
        sendQ.push_back(28'h6332211);
        drain(20);

        // Filter stall of three cycles on the middle word.
        sendQ.push_back(28'h6332211);
        cycle();
        cycle();
        filter_ready = 1'b0;
        repeat (3) cycle();
        filter_ready = 1'b1;
        drain(20);

        // Out-of-range row is dropped, then the next packet follows immediately.
        sendQ.push_back(28'h7AABBCC);
        sendQ.push_back(28'h0030201);
        drain(20);

        // Back-to-back ifmap packets at one word per cycle.
        sendQ.push_back(28'h0030201);
        sendQ.push_back(28'h0060504);
        drain(20);

        // Reset right after the first word, then a fresh packet starts at idx 0.
        sendQ.push_back(28'h0030201);
        cycle();
        cycle();
        doReset();
        sendQ.delete();
        sendQ.push_back(28'h6332211);
        drain(20);

        // Randomized packets with random gaps and downstream backpressure.
        randGaps = 1'b1;
        for (int n = 0; n < 150; n++) begin
            logic [PKT_W-1:0] p;
            p = PKT_W'({$urandom, $urandom});
            sendQ.push_back(p);
        end
        begin
            int left = 4000;
            while ((sendQ.size() > 0 || offering || ifQ.size() > 0 || fQ.size() > 0) && left > 0) begin
                ifmap_ready  = ($urandom_range(3) != 0);
                filter_ready = ($urandom_range(3) != 0);
                cycle();
                left--;
            end
            if (left == 0) begin
                errors++;
                $error("FAIL random_timeout: observed %0d packets pending expected 0", sendQ.size());
            end
        end
        ifmap_ready  = 1'b1;
        filter_ready = 1'b1;
        drain(20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
